rf_access_ctrl: RTL and testbench

Write-port arbiter and sequencer for the two-register file (R1/R2). Two independent requesters, A and B, compete for the file's single write port. A third command, SWAP, exchanges the contents of R1 and R2 as an atomic two-write sequence. The block sits between the requesters and the register file: it drives the file's SEL/WR/iData inputs and reads back R1_Value/R2_Value. Read access to the file stays direct and is not arbitrated.

---
 rtl/rf_access_ctrl.sv | 121 ++++++++++++
 tb/tb_rf_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// Write-port arbiter and swap sequencer for a two-register (R1/R2) file.
// Requesters A and B share the single write port round-robin; SWAP has top priority.
module rf_access_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic             SEL_A,
  input  logic [WIDTH-1:0] DATA_A,
  output logic             ACK_A,
  input  logic             REQ_B,
  input  logic             SEL_B,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             ACK_B,
  input  logic             SWAP_REQ,
  output logic             SWAP_ACK,
  input  logic [WIDTH-1:0] R1_Value,
  input  logic [WIDTH-1:0] R2_Value,
  output logic             RF_SEL,
  output logic             RF_WR,
  output logic [WIDTH-1:0] RF_DATA,
  output logic             BUSY
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_SWP1  = 2'd2;
  localparam logic [1:0] S_SWP2  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             wsel_q, wsel_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] t1_q, t1_d;
  logic [WIDTH-1:0] t2_q, t2_d;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wsel_d  = wsel_q;
    wdata_d = wdata_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    case (state_q)
      S_IDLE: begin
        if (SWAP_REQ) begin
          t1_d    = R1_Value;
          t2_d    = R2_Value;
          state_d = S_SWP1;
        end else if (REQ_A && (!REQ_B || rr_q)) begin
          // A wins when alone, or on a tie when B was granted last
          wsel_d  = SEL_A;
          wdata_d = DATA_A;
          rr_d    = 1'b0;
          state_d = S_WRITE;
        end else if (REQ_B) begin
          wsel_d  = SEL_B;
          wdata_d = DATA_B;
          rr_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_SWP1:  state_d = S_SWP2;
      S_SWP2:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b1;
      wsel_q  <= 1'b0;
      wdata_q <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wsel_q  <= wsel_d;
      wdata_q <= wdata_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
    end
  end

  // Outputs decode purely from registered state; rr_q identifies the WRITE owner
  always_comb begin
    RF_WR    = 1'b0;
    RF_SEL   = 1'b0;
    RF_DATA  = '0;
    ACK_A    = 1'b0;
    ACK_B    = 1'b0;
    SWAP_ACK = 1'b0;
    BUSY     = (state_q != S_IDLE);
    case (state_q)
      S_WRITE: begin
        RF_WR   = 1'b1;
        RF_SEL  = wsel_q;
        RF_DATA = wdata_q;
        ACK_A   = ~rr_q;
        ACK_B   = rr_q;
      end
      S_SWP1: begin
        RF_WR   = 1'b1;
        RF_SEL  = 1'b0;
        RF_DATA = t2_q;
      end
      S_SWP2: begin
        RF_WR    = 1'b1;
        RF_SEL   = 1'b1;
        RF_DATA  = t1_q;
        SWAP_ACK = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: directed vector table, reset-mid-swap sequence,
// then randomized traffic against a transaction-queue reference model.
module tb_rf_access_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         REQ_A, SEL_A, REQ_B, SEL_B, SWAP_REQ;
  logic [W-1:0] DATA_A, DATA_B;
  logic         ACK_A, ACK_B, SWAP_ACK, RF_SEL, RF_WR, BUSY;
  logic [W-1:0] RF_DATA, R1_Value, R2_Value;

  // Register file the arbiter drives; it has no reset of its own
  logic [W-1:0] rf_r1 = '0;
  logic [W-1:0] rf_r2 = '0;
  always @(posedge CLK) begin
    if (RF_WR) begin
      if (RF_SEL) rf_r2 <= RF_DATA;
      else        rf_r1 <= RF_DATA;
    end
  end
  assign R1_Value = rf_r1;
  assign R2_Value = rf_r2;

  rf_access_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_A(REQ_A), .SEL_A(SEL_A), .DATA_A(DATA_A), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .SEL_B(SEL_B), .DATA_B(DATA_B), .ACK_B(ACK_B),
    .SWAP_REQ(SWAP_REQ), .SWAP_ACK(SWAP_ACK),
    .R1_Value(R1_Value), .R2_Value(R2_Value),
    .RF_SEL(RF_SEL), .RF_WR(RF_WR), .RF_DATA(RF_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         wr;
    logic         sel;
    logic [W-1:0] data;
    logic         aa;
    logic         ab;
    logic         sack;
    logic         busy;
  } exp_t;

  typedef struct {
    logic rst, ra, sa; logic [W-1:0] da;
    logic rb, sb;      logic [W-1:0] db;
    logic sw;
    exp_t e;
    logic [W-1:0] r1, r2;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  function automatic exp_t idle_c();
    return '0;
  endfunction

  function automatic exp_t wr_c(input logic sel, input logic [W-1:0] d,
                                input logic aa, input logic ab, input logic sack);
    exp_t e;
    e = '{wr: 1'b1, sel: sel, data: d, aa: aa, ab: ab, sack: sack, busy: 1'b1};
    return e;
  endfunction

  function automatic exp_t dut_outs();
    exp_t e;
    e = '{wr: RF_WR, sel: RF_SEL, data: RF_DATA, aa: ACK_A, ab: ACK_B,
          sack: SWAP_ACK, busy: BUSY};
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic ra, input logic sa, input logic [W-1:0] da,
                     input logic rb, input logic sb, input logic [W-1:0] db, input logic sw,
                     input exp_t e, input logic [W-1:0] r1, input logic [W-1:0] r2);
    vec_t v;
    v = '{rst: rst, ra: ra, sa: sa, da: da, rb: rb, sb: sb, db: db, sw: sw,
          e: e, r1: r1, r2: r2};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ra, input logic sa, input logic [W-1:0] da,
                       input logic rb, input logic sb, input logic [W-1:0] db, input logic sw);
    RST = rst; REQ_A = ra; SEL_A = sa; DATA_A = da;
    REQ_B = rb; SEL_B = sb; DATA_B = db; SWAP_REQ = sw;
  endtask

  task automatic step_check(input string name, input exp_t e,
                            input logic [W-1:0] r1, input logic [W-1:0] r2);
    @(posedge CLK);
    @(negedge CLK);
    check({name, ".outs"}, 32'(dut_outs()), 32'(e));
    check({name, ".r1"}, 32'(R1_Value), 32'(r1));
    check({name, ".r2"}, 32'(R2_Value), 32'(r2));
  endtask

  // Reference model: a queue of scheduled output cycles plus the register contents
  exp_t         m_q[$];
  exp_t         m_cur, m_prev;
  logic         m_rr;
  logic [W-1:0] m_reg[2];

  task automatic model_edge();
    m_prev = m_cur;
    if (m_prev.wr) m_reg[m_prev.sel] = m_prev.data;
    if (RST) begin
      m_q.delete();
      m_cur = idle_c();
      m_rr  = 1'b1;
    end else begin
      if (!m_prev.busy) begin
        if (SWAP_REQ) begin
          m_q.push_back(wr_c(1'b0, m_reg[1], 1'b0, 1'b0, 1'b0));
          m_q.push_back(wr_c(1'b1, m_reg[0], 1'b0, 1'b0, 1'b1));
        end else if (REQ_A || REQ_B) begin
          logic win_b;
          win_b = (REQ_A && REQ_B) ? !m_rr : REQ_B;
          m_rr  = win_b;
          if (win_b) m_q.push_back(wr_c(SEL_B, DATA_B, 1'b0, 1'b1, 1'b0));
          else       m_q.push_back(wr_c(SEL_A, DATA_A, 1'b1, 1'b0, 1'b0));
        end
      end
      m_cur = (m_q.size() > 0) ? m_q.pop_front() : idle_c();
    end
  endtask

  initial begin
    logic a_pend, b_pend, s_pend;
    drive(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 8'hBB, 1'b1);

    // inputs applied before edge i, expectations observed after edge i
    add(1, 1,0,8'hAA, 1,1,8'hBB, 1, idle_c(),                    8'h00, 8'h00);
    add(1, 1,0,8'hAA, 1,1,8'hBB, 1, idle_c(),                    8'h00, 8'h00);
    add(0, 1,0,8'h5A, 1,1,8'h66, 0, wr_c(0, 8'h5A, 1, 0, 0),     8'h00, 8'h00);
    add(0, 1,0,8'h5A, 1,1,8'h66, 0, idle_c(),                    8'h5A, 8'h00);
    add(0, 0,0,8'h00, 1,1,8'h66, 0, wr_c(1, 8'h66, 0, 1, 0),     8'h5A, 8'h00);
    add(0, 0,0,8'h00, 1,1,8'h66, 0, idle_c(),                    8'h5A, 8'h66);
    add(0, 1,1,8'hC3, 0,0,8'h00, 0, wr_c(1, 8'hC3, 1, 0, 0),     8'h5A, 8'h66);
    add(0, 1,1,8'hC3, 0,0,8'h00, 0, idle_c(),                    8'h5A, 8'hC3);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, wr_c(1, 8'h22, 0, 1, 0),     8'h5A, 8'hC3);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, idle_c(),                    8'h5A, 8'h22);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, wr_c(0, 8'h11, 1, 0, 0),     8'h5A, 8'h22);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, idle_c(),                    8'h11, 8'h22);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, wr_c(1, 8'h22, 0, 1, 0),     8'h11, 8'h22);
    add(0, 1,0,8'h11, 1,1,8'h22, 0, idle_c(),                    8'h11, 8'h22);
    add(0, 1,0,8'h12, 1,1,8'h34, 0, wr_c(0, 8'h12, 1, 0, 0),     8'h11, 8'h22);
    add(0, 1,0,8'h12, 1,1,8'h34, 0, idle_c(),                    8'h12, 8'h22);
    add(0, 0,0,8'h00, 1,1,8'h34, 0, wr_c(1, 8'h34, 0, 1, 0),     8'h12, 8'h22);
    add(0, 0,0,8'h00, 1,1,8'h34, 0, idle_c(),                    8'h12, 8'h34);
    add(0, 0,0,8'h00, 0,0,8'h00, 1, wr_c(0, 8'h34, 0, 0, 0),     8'h12, 8'h34);
    add(0, 0,0,8'h00, 0,0,8'h00, 0, wr_c(1, 8'h12, 0, 0, 1),     8'h34, 8'h34);
    add(0, 0,0,8'h00, 0,0,8'h00, 0, idle_c(),                    8'h34, 8'h12);
    add(0, 1,1,8'h77, 0,0,8'h00, 1, wr_c(0, 8'h12, 0, 0, 0),     8'h34, 8'h12);
    add(0, 1,1,8'h77, 0,0,8'h00, 0, wr_c(1, 8'h34, 0, 0, 1),     8'h12, 8'h12);
    add(0, 1,1,8'h77, 0,0,8'h00, 0, idle_c(),                    8'h12, 8'h34);
    add(0, 1,1,8'h77, 0,0,8'h00, 0, wr_c(1, 8'h77, 1, 0, 0),     8'h12, 8'h34);
    add(0, 1,1,8'h77, 0,0,8'h00, 0, idle_c(),                    8'h12, 8'h77);
    add(0, 1,1,8'h34, 0,0,8'h00, 0, wr_c(1, 8'h34, 1, 0, 0),     8'h12, 8'h77);
    add(0, 1,1,8'h34, 0,0,8'h00, 0, idle_c(),                    8'h12, 8'h34);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ra, tbl[i].sa, tbl[i].da,
            tbl[i].rb, tbl[i].sb, tbl[i].db, tbl[i].sw);
      step_check($sformatf("vec%0d", i), tbl[i].e, tbl[i].r1, tbl[i].r2);
    end

    // Reset lands at the edge that would enter SWP2: SWP1 write lands, swap abandoned.
    // rr was last A, so the post-reset tie going to A proves rr was reset.
    drive(0, 0,0,8'h00, 0,0,8'h00, 1);
    step_check("mid_swap.swp1", wr_c(0, 8'h34, 0, 0, 0), 8'h12, 8'h34);
    drive(1, 0,0,8'h00, 0,0,8'h00, 1);
    step_check("mid_swap.rst", idle_c(), 8'h34, 8'h34);
    drive(0, 0,0,8'h00, 0,0,8'h00, 0);
    step_check("mid_swap.after", idle_c(), 8'h34, 8'h34);
    drive(0, 1,0,8'hA1, 1,1,8'hB2, 0);
    step_check("post_rst.tie", wr_c(0, 8'hA1, 1, 0, 0), 8'h34, 8'h34);
    drive(0, 0,0,8'h00, 1,1,8'hB2, 0);
    step_check("post_rst.idle", idle_c(), 8'hA1, 8'h34);
    step_check("post_rst.b", wr_c(1, 8'hB2, 0, 1, 0), 8'hA1, 8'h34);
    drive(0, 0,0,8'h00, 0,0,8'h00, 0);
    step_check("post_rst.end", idle_c(), 8'hA1, 8'hB2);

    // Randomized traffic following the hold-until-ACK protocol
    m_reg[0] = rf_r1;
    m_reg[1] = rf_r2;
    m_cur = idle_c();
    m_rr  = 1'b1;
    a_pend = 1'b0; b_pend = 1'b0; s_pend = 1'b0;
    RST = 1'b1;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      model_edge();
      #1;
      if (m_prev.aa)   a_pend = 1'b0;
      if (m_prev.ab)   b_pend = 1'b0;
      if (m_prev.sack) s_pend = 1'b0;
      if (!a_pend && ($urandom_range(3) != 0)) begin
        a_pend = 1'b1; SEL_A = 1'($urandom); DATA_A = W'($urandom);
      end
      if (!b_pend && ($urandom_range(3) != 0)) begin
        b_pend = 1'b1; SEL_B = 1'($urandom); DATA_B = W'($urandom);
      end
      if (!s_pend && ($urandom_range(15) == 0)) s_pend = 1'b1;
      REQ_A = a_pend; REQ_B = b_pend; SWAP_REQ = s_pend;
      RST = ($urandom_range(99) == 0);
      @(negedge CLK);
      check("rand.outs", 32'(dut_outs()), 32'(m_cur));
      check("rand.r1", 32'(R1_Value), 32'(m_reg[0]));
      check("rand.r2", 32'(R2_Value), 32'(m_reg[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
